// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one downstream memory port between the icache refill path and the
//   dcache refill/writeback path. One requester is granted at a time, its
//   command is latched onto the mem_* registers and held until mem_ok, then the
//   response is returned with a one-cycle done pulse. Ties are broken
//   round-robin; after reset the dcache wins the first tie.
//
//   Optional build macro ARB_TIMEOUT_EN adds a watchdog: after TIMEOUT granted
//   cycles without mem_ok the transaction is completed with zero read data and
//   mem_timeout pulses for one cycle. Without the macro the arbiter waits
//   indefinitely and the mem_timeout port does not exist.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_req/i_addr             icache read request (level, held until i_ok)
//   i_rdata/i_ok             icache read data (32b) and done pulse
//   d_req/d_we/d_addr/
//   d_wdata/d_wmask          dcache request (level, held until d_ok)
//   d_rdata/d_ok             dcache read data (0 on writes) and done pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wmask      memory command, held until mem_ok
//   mem_rdata/mem_ok         memory read data and completion pulse
//   mem_timeout              watchdog expiry pulse (ARB_TIMEOUT_EN only)
//   busy                     1 whenever the arbiter is not idle
module mem_port_arbiter #(
   parameter int ADDR_W  = 64,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [31:0]       i_rdata,
   output logic              i_ok,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [63:0]       d_wdata,
   input  logic [7:0]        d_wmask,
   output logic [63:0]       d_rdata,
   output logic              d_ok,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   output logic [7:0]        mem_wmask,
   input  logic [63:0]       mem_rdata,
   input  logic              mem_ok,
`ifdef ARB_TIMEOUT_EN
   output logic              mem_timeout,
`endif
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

   state_t            state, state_nx;
   logic              last_d, last_d_nx;   // 1: last grant went to dcache
   logic              mem_req_nx;
   logic              mem_we_nx;
   logic [ADDR_W-1:0] mem_addr_nx;
   logic [63:0]       mem_wdata_nx;
   logic [7:0]        mem_wmask_nx;
   logic [31:0]       i_rdata_nx;
   logic              i_ok_nx;
   logic [63:0]       d_rdata_nx;
   logic              d_ok_nx;
   logic              busy_nx;

`ifdef ARB_TIMEOUT_EN
   logic [7:0]        wd_cnt, wd_cnt_nx;
   logic              mem_timeout_nx;
   logic              wd_expired;

   assign wd_expired = (wd_cnt == 8'(TIMEOUT));
`else
   logic [7:0]        unused_timeout;

   assign unused_timeout = 8'(TIMEOUT);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         last_d    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
         i_rdata   <= '0;
         i_ok      <= 1'b0;
         d_rdata   <= '0;
         d_ok      <= 1'b0;
         busy      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         wd_cnt      <= '0;
         mem_timeout <= 1'b0;
`endif
      end else begin
         state     <= state_nx;
         last_d    <= last_d_nx;
         mem_req   <= mem_req_nx;
         mem_we    <= mem_we_nx;
         mem_addr  <= mem_addr_nx;
         mem_wdata <= mem_wdata_nx;
         mem_wmask <= mem_wmask_nx;
         i_rdata   <= i_rdata_nx;
         i_ok      <= i_ok_nx;
         d_rdata   <= d_rdata_nx;
         d_ok      <= d_ok_nx;
         busy      <= busy_nx;
`ifdef ARB_TIMEOUT_EN
         wd_cnt      <= wd_cnt_nx;
         mem_timeout <= mem_timeout_nx;
`endif
      end
   end

   always_comb begin
      state_nx     = state;
      last_d_nx    = last_d;
      mem_req_nx   = mem_req;
      mem_we_nx    = mem_we;
      mem_addr_nx  = mem_addr;
      mem_wdata_nx = mem_wdata;
      mem_wmask_nx = mem_wmask;
      i_rdata_nx   = i_rdata;
      i_ok_nx      = 1'b0;
      d_rdata_nx   = d_rdata;
      d_ok_nx      = 1'b0;
`ifdef ARB_TIMEOUT_EN
      wd_cnt_nx      = wd_cnt;
      mem_timeout_nx = 1'b0;
`endif

      case (state)
         IDLE: begin
            // dcache wins when alone, or on a tie if icache had the last grant
            if (d_req && (!i_req || !last_d)) begin
               state_nx     = GNT_D;
               last_d_nx    = 1'b1;
               mem_req_nx   = 1'b1;
               mem_we_nx    = d_we;
               mem_addr_nx  = d_addr;
               mem_wdata_nx = d_wdata;
               mem_wmask_nx = d_wmask;
`ifdef ARB_TIMEOUT_EN
               wd_cnt_nx    = '0;
`endif
            end else if (i_req) begin
               state_nx     = GNT_I;
               last_d_nx    = 1'b0;
               mem_req_nx   = 1'b1;
               mem_we_nx    = 1'b0;
               mem_addr_nx  = i_addr;
               mem_wdata_nx = '0;
               mem_wmask_nx = '1;
`ifdef ARB_TIMEOUT_EN
               wd_cnt_nx    = '0;
`endif
            end
         end

         GNT_I: begin
            if (mem_ok) begin
               state_nx   = RESP;
               mem_req_nx = 1'b0;
               i_ok_nx    = 1'b1;
               i_rdata_nx = mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
`ifdef ARB_TIMEOUT_EN
            end else if (wd_expired) begin
               state_nx       = RESP;
               mem_req_nx     = 1'b0;
               i_ok_nx        = 1'b1;
               i_rdata_nx     = '0;
               mem_timeout_nx = 1'b1;
            end else begin
               wd_cnt_nx = wd_cnt + 8'd1;
`endif
            end
         end

         GNT_D: begin
            if (mem_ok) begin
               state_nx   = RESP;
               mem_req_nx = 1'b0;
               d_ok_nx    = 1'b1;
               d_rdata_nx = mem_we ? 64'd0 : mem_rdata;
`ifdef ARB_TIMEOUT_EN
            end else if (wd_expired) begin
               state_nx       = RESP;
               mem_req_nx     = 1'b0;
               d_ok_nx        = 1'b1;
               d_rdata_nx     = '0;
               mem_timeout_nx = 1'b1;
            end else begin
               wd_cnt_nx = wd_cnt + 8'd1;
`endif
            end
         end

         // Requests are not sampled here so a req still held during the ok
         // pulse cannot start a duplicate transaction.
         RESP: begin
            state_nx = IDLE;
         end

         default: begin
            state_nx = IDLE;
         end
      endcase

      busy_nx = (state_nx != IDLE);
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [63:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_ok;
   logic        d_req;
   logic        d_we;
   logic [63:0] d_addr;
   logic [63:0] d_wdata;
   logic [7:0]  d_wmask;
   logic [63:0] d_rdata;
   logic        d_ok;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic [63:0] mem_rdata;
   logic        mem_ok;
   logic        busy;
`ifdef ARB_TIMEOUT_EN
   logic        mem_timeout;
`endif

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.ADDR_W(64), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ok(i_ok),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wmask(d_wmask), .d_rdata(d_rdata), .d_ok(d_ok),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
      .mem_ok(mem_ok),
`ifdef ARB_TIMEOUT_EN
      .mem_timeout(mem_timeout),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_req"},   64'(mem_req),   64'd0);
      chk({tag, "_mem_we"},    64'(mem_we),    64'd0);
      chk({tag, "_mem_addr"},  mem_addr,       64'd0);
      chk({tag, "_mem_wdata"}, mem_wdata,      64'd0);
      chk({tag, "_mem_wmask"}, 64'(mem_wmask), 64'd0);
      chk({tag, "_i_ok"},      64'(i_ok),      64'd0);
      chk({tag, "_i_rdata"},   64'(i_rdata),   64'd0);
      chk({tag, "_d_ok"},      64'(d_ok),      64'd0);
      chk({tag, "_d_rdata"},   d_rdata,        64'd0);
      chk({tag, "_busy"},      64'(busy),      64'd0);
   endtask

   initial begin
      rst = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
      d_wdata = '0; d_wmask = '0; mem_rdata = '0; mem_ok = 0;
      tick; tick;
      chk_all_zero("reset");
      rst = 1'b0;
      tick;

      // icache read, upper word selected by addr[2]
      i_req = 1; i_addr = 64'h8000_0004;              // cycle 0
      tick;                                           // cycle 1
      chk("i_mem_req_c1", 64'(mem_req), 64'd1);
      chk("i_mem_we",     64'(mem_we),  64'd0);
      chk("i_mem_addr",   mem_addr,     64'h8000_0004);
      chk("i_mem_wmask",  64'(mem_wmask), 64'hFF);
      chk("i_busy",       64'(busy),    64'd1);
      tick; tick; tick;                               // cycle 4
      chk("i_mem_req_c4", 64'(mem_req), 64'd1);
      chk("i_ok_c4",      64'(i_ok),    64'd0);
      mem_ok = 1; mem_rdata = 64'h1111_2222_3333_4444;
      tick;                                           // cycle 5
      mem_ok = 0; mem_rdata = '0;
      chk("i_ok_c5",      64'(i_ok),    64'd1);
      chk("i_rdata_c5",   64'(i_rdata), 64'h1111_2222);
      chk("i_mem_req_c5", 64'(mem_req), 64'd0);
      tick;                                           // cycle 6, i_req still held
      chk("i_ok_c6",      64'(i_ok),    64'd0);
      chk("i_busy_c6",    64'(busy),    64'd0);
      i_req = 0;
      tick;                                           // cycle 7
      chk("no_dup_req",   64'(mem_req), 64'd0);
      chk("no_dup_busy",  64'(busy),    64'd0);

      // stray mem_ok while idle
      mem_ok = 1; mem_rdata = 64'h5555_5555_5555_5555;
      tick;
      mem_ok = 0; mem_rdata = '0;
      chk("idle_ok_i",    64'(i_ok),    64'd0);
      chk("idle_ok_d",    64'(d_ok),    64'd0);
      chk("idle_ok_busy", 64'(busy),    64'd0);

      // dcache write
      d_req = 1; d_we = 1; d_addr = 64'h8000_0010;
      d_wdata = 64'hDEAD_BEEF_0000_0001; d_wmask = 8'h0F;
      tick;
      chk("d_mem_req",   64'(mem_req),   64'd1);
      chk("d_mem_we",    64'(mem_we),    64'd1);
      chk("d_mem_addr",  mem_addr,       64'h8000_0010);
      chk("d_mem_wdata", mem_wdata,      64'hDEAD_BEEF_0000_0001);
      chk("d_mem_wmask", 64'(mem_wmask), 64'h0F);
      d_wdata = '0; d_addr = 64'h4444; d_wmask = 8'hFF; d_we = 0;
      tick;
      chk("d_hold_wdata", mem_wdata,      64'hDEAD_BEEF_0000_0001);
      chk("d_hold_addr",  mem_addr,       64'h8000_0010);
      chk("d_hold_wmask", 64'(mem_wmask), 64'h0F);
      chk("d_hold_we",    64'(mem_we),    64'd1);
      mem_ok = 1; mem_rdata = 64'hCAFE_F00D_1234_5678;
      tick;
      mem_ok = 0; mem_rdata = '0; d_req = 0;
      chk("d_ok_wr",      64'(d_ok),    64'd1);
      chk("d_rdata_wr",   d_rdata,      64'd0);
      chk("d_wr_no_i_ok", 64'(i_ok),    64'd0);
      tick;
      chk("d_ok_clear",   64'(d_ok),    64'd0);
      chk("d_busy_clear", 64'(busy),    64'd0);

      // icache drops req while granted; lower word selected
      i_req = 1; i_addr = 64'h1000;
      tick;
      chk("drop_mem_addr", mem_addr, 64'h1000);
      i_req = 0;
      tick; tick;
      mem_ok = 1; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
      tick;
      mem_ok = 0; mem_rdata = '0;
      chk("drop_i_ok",    64'(i_ok),    64'd1);
      chk("drop_i_rdata", 64'(i_rdata), 64'hCCCC_DDDD);
      tick;

      // round-robin tie after reset
      rst = 1; tick; rst = 0; tick;
      i_req = 1; i_addr = 64'h2008;
      d_req = 1; d_we = 0; d_addr = 64'h3000; d_wmask = 8'hFF;
      tick;
      chk("tie1_addr", mem_addr,     64'h3000);
      chk("tie1_we",   64'(mem_we),  64'd0);
      mem_ok = 1; mem_rdata = 64'h0123_4567_89AB_CDEF;
      tick;
      mem_ok = 0; mem_rdata = '0; d_req = 0;
      chk("tie1_d_ok",    64'(d_ok),  64'd1);
      chk("tie1_d_rdata", d_rdata,    64'h0123_4567_89AB_CDEF);
      chk("tie1_i_ok",    64'(i_ok),  64'd0);
      tick;
      chk("tie_gap_req",  64'(mem_req), 64'd0);
      chk("tie_gap_busy", 64'(busy),    64'd0);
      tick;
      chk("tie2_req",  64'(mem_req), 64'd1);
      chk("tie2_addr", mem_addr,     64'h2008);
      mem_ok = 1; mem_rdata = 64'hFEDC_BA98_7654_3210;
      tick;
      mem_ok = 0; mem_rdata = '0; i_req = 0;
      chk("tie2_i_ok",    64'(i_ok),    64'd1);
      chk("tie2_i_rdata", 64'(i_rdata), 64'h7654_3210);
      tick;
      i_req = 1; d_req = 1;
      tick;
      chk("tie3_addr", mem_addr,     64'h3000);
      chk("tie3_req",  64'(mem_req), 64'd1);

      // reset in the middle of a dcache grant
      rst = 1;
      #1;
      chk("rst_async_req",  64'(mem_req), 64'd0);
      chk("rst_async_busy", 64'(busy),    64'd0);
      tick;
      chk_all_zero("rst_mid");
      rst = 0; i_req = 0; d_req = 0;
      tick;
      chk("post_rst_busy", 64'(busy), 64'd0);

`ifdef ARB_TIMEOUT_EN
      // watchdog: TIMEOUT=8, no mem_ok
      i_req = 1; i_addr = 64'h8000_0004;
      tick;                                           // cycle 1
      chk("to_req_c1", 64'(mem_req), 64'd1);
      for (int c = 2; c <= 9; c++) begin
         tick;
         chk("to_wait_i_ok",  64'(i_ok),        64'd0);
         chk("to_wait_flag",  64'(mem_timeout), 64'd0);
      end
      tick;                                           // cycle 10
      chk("to_i_ok",   64'(i_ok),        64'd1);
      chk("to_rdata",  64'(i_rdata),     64'd0);
      chk("to_flag",   64'(mem_timeout), 64'd1);
      chk("to_req",    64'(mem_req),     64'd0);
      i_req = 0; mem_ok = 1; mem_rdata = 64'h9999_9999_9999_9999;
      tick;
      mem_ok = 0; mem_rdata = '0;
      chk("to_flag_clr", 64'(mem_timeout), 64'd0);
      chk("to_late_ok",  64'(i_ok),        64'd0);
      chk("to_busy",     64'(busy),        64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single downstream memory port between the instruction-cache refill path and the data-cache refill/writeback path.
- Grants one requester at a time, latches that requester's command, holds it on the memory port until the memory signals completion, then routes the response back with a one-cycle done pulse.
- Sits between i_cache1 / d_cache1 and the AXI4 bridge.

Parameters:
- ADDR_W, 64, address width on all ports.
- TIMEOUT, 255, cycle limit for the watchdog; only used with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- i_req  in  1  icache read request; level, held until i_ok
- i_addr  in  ADDR_W  icache read address
- i_rdata  out  32  icache read data, valid while i_ok=1
- i_ok  out  1  icache done pulse, 1 cycle
- d_req  in  1  dcache request; level, held until d_ok
- d_we  in  1  dcache write (1) / read (0)
- d_addr  in  ADDR_W  dcache address
- d_wdata  in  64  dcache write data
- d_wmask  in  8  dcache byte strobes
- d_rdata  out  64  dcache read data, valid while d_ok=1
- d_ok  out  1  dcache done pulse, 1 cycle
- mem_req  out  1  memory command valid; held until mem_ok
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  64  memory write data
- mem_wmask  out  8  memory byte strobes
- mem_rdata  in  64  memory read data, valid with mem_ok
- mem_ok  in  1  memory completion, 1-cycle pulse
- busy  out  1  1 whenever state is not IDLE

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, last_grant=I.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, i_ok, i_rdata, d_ok, d_rdata, busy.
- States: IDLE, GNT_I, GNT_D, RESP. All outputs are registered.
- IDLE:
  - Only d_req: go to GNT_D.
  - Only i_req: go to GNT_I.
  - Both: grant the requester opposite last_grant (round-robin); after reset, dcache wins the first tie.
  - On entry to a GNT state: latch addr/we/wdata/wmask into the mem_* registers, set mem_req=1, update last_grant.
  - Icache grants drive mem_we=0 and mem_wmask=8'hFF.
- GNT_x:
  - Hold mem_* stable until mem_ok.
  - On mem_ok: drop mem_req and go to RESP.
  - For I: i_rdata = mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0], and i_ok=1.
  - For D: d_rdata = mem_rdata (0 on writes), and d_ok=1.
- RESP:
  - One cycle with the ok pulse visible to the requester, which must drop its req next cycle.
  - Clear the ok pulse and go to IDLE.
  - Requests are never sampled in RESP, which prevents a duplicate transaction from a still-held req.
- Latency:
  - req first seen in IDLE at cycle 0 → mem_req=1 at cycle 1.
  - mem_ok at cycle N → x_ok=1 at N+1 → IDLE at N+2 → earliest next mem_req at N+3.
- Requester drops req while granted: the transaction still completes and the ok pulse is still generated.
- Input changes while granted: ignored, because the command is latched.
- mem_ok while in IDLE or RESP: ignored.
- The non-granted requester waits. Round-robin bounds its wait to one transaction.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. The outstanding memory transaction is abandoned, and the bridge must be reset together with the arbiter.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Adds output port mem_timeout (1 bit) and an 8-bit watchdog counter, cleared on entry to GNT_x and incremented each GNT cycle without mem_ok.
  - When the counter reaches TIMEOUT: go to RESP with x_ok=1, read data=0, mem_req=0, and mem_timeout=1 for that cycle.
  - A late mem_ok is ignored.
- Undefined: no counter and no mem_timeout port; the arbiter waits indefinitely in GNT_x.

Test Plan:
- Reset with rst=1 mid-GNT_D, mem_req=1 → next edge: all outputs 0, state IDLE, busy=0.
- i_req=1, i_addr=0x8000_0004; mem_ok at cycle 4 with mem_rdata=0x1111_2222_3333_4444 → mem_req on cycles 1..4, mem_we=0, i_ok=1 at cycle 5 with i_rdata=0x1111_2222, busy=0 at cycle 6.
- d_req=1, d_we=1, d_addr=0x8000_0010, d_wdata=0xDEAD_BEEF_0000_0001, d_wmask=0x0F → mem_* carries exactly these values; d_ok pulse with d_rdata=0.
- i_req and d_req both asserted after reset, each held until its ok → dcache granted first, icache second; the next tie goes to dcache again.
- i_req held one extra cycle after i_ok → exactly one memory transaction issued.
- With ARB_TIMEOUT_EN and TIMEOUT=8, i_req with no mem_ok → i_ok=1, i_rdata=0, mem_timeout=1 nine cycles after mem_req first rose.
